// File: rtl/pattern_scan_pkg.sv
// Shared types and defaults for the pattern scan controller and its serial matcher.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned PAT_W_DEF  = 3;

    // Wide enough for DATA_W-PAT_W+1 matches.
    function automatic int unsigned cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word-in / count-out handshake bundle between the producer/consumer and the scan controller.
interface pattern_scan_ctrl_if
    import pattern_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PAT_W  = PAT_W_DEF,
    parameter int unsigned CNT_W  = cnt_w(DATA_W)
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PAT_W-1:0]  pattern;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;

    modport master (
        output in_valid,
        output in_data,
        output pattern,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  out_hit
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  pattern,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output out_hit
    );

endinterface

// File: rtl/seq_match.sv
// Serial overlapping sequence detector: history shift register, fill counter and comparator.
module seq_match #(
    parameter int unsigned PAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_q;

    assign hist_next = {hist_q[PAT_W-2:0], bit_in};

    // Match looks at the history including the bit arriving this cycle.
    assign match = en && (fill_q >= FILL_W'(PAT_W - 1)) && (hist_next == pattern);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (en) begin
            hist_q <= hist_next;
            if (fill_q != FILL_W'(PAT_W)) begin
                fill_q <= fill_q + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Accepts a word, shifts it MSB-first through seq_match and returns the per-word match count.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PAT_W  = PAT_W_DEF,
    parameter int unsigned CNT_W  = cnt_w(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    pattern_scan_ctrl_if.slave bus,
    output logic               busy,
    output logic               ser_bit,
    output logic               det_pulse
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] word_q;
    logic [PAT_W-1:0]  pat_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [CNT_W-1:0]  count_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              det_q;

    logic accept;
    logic shifting;
    logic match;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign shifting = (state_q == SHIFT);

    seq_match #(
        .PAT_W (PAT_W)
    ) u_seq_match (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (shifting),
        .bit_in  (word_q[DATA_W-1]),
        .pattern (pat_q),
        .match   (match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            pat_q       <= '0;
            bit_idx_q   <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            det_q       <= 1'b0;
        end else begin
            det_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        word_q     <= bus.in_data;
                        pat_q      <= bus.pattern;
                        bit_idx_q  <= '0;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    word_q    <= word_q << 1;
                    bit_idx_q <= bit_idx_q + IDX_W'(1);
                    if (match) begin
                        count_q <= count_q + CNT_W'(1);
                        det_q   <= 1'b1;
                    end
                    if (bit_idx_q == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Count is frozen here; it only restarts on the next accept.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = count_q;
    assign bus.out_hit   = |count_q;
    assign busy          = busy_q;
    // The word register drains to zero, so this reads 0 outside SHIFT.
    assign ser_bit       = word_q[DATA_W-1];
    assign det_pulse     = det_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: directed words with hand-computed match counts.
module tb_pattern_scan_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 3;
    localparam int unsigned CW = 4;

    typedef struct {
        int cnt;
        int hit;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;
    logic ser_bit;
    logic det_pulse;

    exp_t sb[$];
    int   n_cmp;
    int   n_fail;

    pattern_scan_ctrl_if #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) bus ();

    pattern_scan_ctrl #(
        .DATA_W (DW),
        .PAT_W  (PW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .ser_bit   (ser_bit),
        .det_pulse (det_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_count", int'(bus.out_count), e.cnt);
                check("out_hit", int'(bus.out_hit), e.hit);
            end
        end
    end

    // Present a word and return #1 after the accept edge.
    task automatic send(input logic [DW-1:0] data, input logic [PW-1:0] pat, input int expc,
                        input bit push);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.pattern  = pat;
        if (push) sb.push_back('{cnt: expc, hit: (expc != 0) ? 1 : 0});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        n_cmp = 0;
        n_fail = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.pattern   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_count", int'(bus.out_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_det_pulse", int'(det_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic scan with latency, ser_bit and det_pulse timing.
        d = 8'b11011011;
        send(d, 3'b110, 2, 1'b1);
        check("basic_busy", int'(busy), 1);
        check("basic_ser_bit0", int'(ser_bit), int'(d[7]));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("basic_det_k%0d", k), int'(det_pulse), (k == 3 || k == 6) ? 1 : 0);
            check($sformatf("basic_valid_k%0d", k), int'(bus.out_valid), (k == 8) ? 1 : 0);
            if (k <= 7) check($sformatf("basic_ser_k%0d", k), int'(ser_bit), int'(d[7-k]));
        end
        drain();

        // Overlapping matches, no match, word boundary.
        send(8'hFF, 3'b111, 6, 1'b1);
        send(8'h00, 3'b000, 6, 1'b1);
        send(8'h00, 3'b110, 0, 1'b1);
        send(8'b00000011, 3'b110, 0, 1'b1);
        send(8'b01010101, 3'b110, 0, 1'b1);
        drain();

        // Backpressure in DONE plus a pattern change mid-SHIFT.
        bus.out_ready = 1'b0;
        send(8'hFF, 3'b111, 6, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.pattern = 3'b000;
        repeat (5) @(posedge clk);
        #1;
        check("bp_valid_entry", int'(bus.out_valid), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_out_count", int'(bus.out_count), 6);
            check("bp_out_hit", int'(bus.out_hit), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_busy", int'(busy), 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        repeat (12) @(posedge clk);
        #1;
        check("bp_no_extra_word", int'(bus.out_valid), 0);

        // Reset in the 4th SHIFT cycle discards the word.
        send(8'b11011011, 3'b110, 2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_in_ready", int'(bus.in_ready), 1);
        check("arst_out_valid", int'(bus.out_valid), 0);
        check("arst_out_count", int'(bus.out_count), 0);
        check("arst_out_hit", int'(bus.out_hit), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ser_bit", int'(ser_bit), 0);
        check("arst_det_pulse", int'(det_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("arst_no_out_valid", int'(bus.out_valid), 0);
        send(8'b11011011, 3'b110, 2, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Word-level controller that sequences a serial pattern detector.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it MSB-first, one bit per cycle, into a programmable PAT_W-bit overlapping sequence matcher.
- Counts the matches found in the word and returns the count over a second valid/ready handshake.
- Sits between a parallel producer (register file or bus) and the serial detection datapath; turns single-bit detection into a per-word result.

Parameters:
- DATA_W, 8: bits per input word.
- PAT_W, 3: pattern length in bits. Must satisfy 2 <= PAT_W <= DATA_W.
- CNT_W, $clog2(DATA_W+1): width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  word to scan, MSB scanned first.
- pattern  input  PAT_W  pattern to detect, MSB is the oldest bit.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_count  output  CNT_W  number of matches in the word; overlapping matches are counted.
- out_hit  output  1  out_count != 0.
- busy  output  1  high in SHIFT or DONE.
- ser_bit  output  1  bit being shifted this cycle (debug).
- det_pulse  output  1  registered one-cycle match pulse (debug).

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE.
  - in_ready = 1; out_valid, out_count, out_hit, busy, ser_bit, det_pulse = 0.
  - Shift register, history, bit index and pattern latch cleared.
- States:
  - IDLE:
    - in_ready = 1.
    - On the in_valid edge: latch in_data and pattern, clear history, count = 0, bit_idx = 0, go to SHIFT.
  - SHIFT:
    - in_ready = 0.
    - Each edge: the MSB of the word register enters history and the word shifts left by 1; bit_idx is incremented.
    - A match is declared when at least PAT_W bits of this word have been shifted and the newest PAT_W history bits equal the latched pattern. On a match, count is incremented and det_pulse = 1 for the next cycle.
    - After the edge that shifts bit DATA_W-1, go to DONE.
  - DONE:
    - out_valid = 1.
    - out_count and out_hit are held stable until the out_ready edge, then go to IDLE.
- Latency and throughput:
  - Word accepted at edge t; out_valid is visible after edge t+DATA_W.
  - Throughput is one word per DATA_W+2 cycles minimum.
  - in_ready is not asserted in DONE, so there is no overlap between words.
- History never spans words. Matches that would straddle a word boundary are not counted.
- The pattern is latched at accept. Changes on the pattern port during SHIFT or DONE are ignored.
- in_valid is ignored while not in IDLE.
- out_ready is ignored while out_valid = 0.
- Count saturation cannot occur: at most DATA_W-PAT_W+1 matches per word, which fits in CNT_W bits.
- If reset asserts mid-SHIFT or mid-DONE, the word and its result are discarded. No out_valid is produced for that word.

Decomposition:
- Shared package pattern_scan_pkg holds:
  - State enum {IDLE, SHIFT, DONE}.
  - Defaults DATA_W_DEF = 8 and PAT_W_DEF = 3.
  - CNT_W function.
- One sub-module seq_match:
  - Ports: clk, rst, clr, en, bit_in, pattern[PAT_W], match.
  - Contains the history shift register, fill counter and comparator. It is the reusable serial detector.
- The top level holds the FSM, word register, bit counter, match counter and handshakes.

Test Plan:
- Basic scan: pattern = 3'b110, in_data = 8'b11011011, out_ready held 1.
  - out_count = 2, out_hit = 1.
  - out_valid first high 8 cycles after the accept edge.
  - det_pulse is high after the 3rd and 6th shifts.
- Overlapping matches: pattern = 3'b111, in_data = 8'hFF.
  - out_count = 6.
  - pattern = 3'b000, in_data = 8'h00: out_count = 6.
- No match: pattern = 3'b110, in_data = 8'h00.
  - out_count = 0, out_hit = 0, and out_valid still asserts.
- Word boundary: pattern = 3'b110. Word 1 = 8'b00000011 gives count 0. Word 2 = 8'b01010101 gives count 0, because no cross-word match is allowed.
- Backpressure and pattern latch:
  - Hold out_ready = 0 for 5 cycles in DONE. out_valid, out_count and out_hit stay stable, in_ready = 0, and a new in_valid is ignored.
  - Changing pattern mid-SHIFT leaves the result unchanged.
- Reset mid-operation:
  - Assert rst at the 4th SHIFT cycle. Outputs return to reset values immediately, with no out_valid for the aborted word.
  - The next word (8'b11011011, pattern 110) then returns out_count = 2.
